// File: rtl/dma_copy_ctrl.sv
// Byte-wise memory-to-memory copy engine behind an 8-byte CPU register window.
// Requests the shared RAM bus, then runs RD/WAIT/LATCH/WR per byte until LEN hits zero or ABORT.
module dma_copy_ctrl #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cs_i,
  input  logic              R_W_n,
  input  logic [2:0]        addr_i,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_data_o,
  input  logic [7:0]        mem_data_i,
  output logic              irq_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WAIT, S_LATCH, S_WR} state_t;

  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_src, r_dst, r_last_addr;
  logic [15:0]       r_len;
  logic [7:0]        r_buf;
  logic [1:0]        r_wcnt;
  logic              r_src_fix, r_dst_fix, r_irq_en;
  logic              r_done, r_aborted, r_abort_pend, r_irq;

  logic w_wr, w_rd_stat, w_busy, w_cfg_wr, w_ctrl_wr, w_start, w_last, w_abort_wr;
  logic w_done_n, w_ab_n, w_irq_en_n;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_wr       = cs_i & ~R_W_n;
  assign w_rd_stat  = cs_i & R_W_n & (addr_i == 3'd7);
  assign w_busy     = (r_state != S_IDLE);
  assign w_cfg_wr   = w_wr & ~w_busy;
  assign w_ctrl_wr  = w_cfg_wr & (addr_i == 3'd6);
  assign w_start    = w_ctrl_wr & data_i[0];
  assign w_abort_wr = w_wr & w_busy & (addr_i == 3'd6) & data_i[7];
  assign w_last     = (r_len == 16'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start && r_len != 16'd0) w_next = S_REQ;
      S_REQ:   if (r_abort_pend) w_next = S_IDLE;
               else if (bus_gnt_i) w_next = S_RD;
      S_RD:    w_next = (RD_LAT == 1) ? S_LATCH : S_WAIT;
      S_WAIT:  if (r_wcnt == WAIT_LAST) w_next = S_LATCH;
      S_LATCH: w_next = S_WR;
      S_WR:    if (w_last || r_abort_pend) w_next = S_IDLE;
               else if (!bus_gnt_i) w_next = S_REQ;
               else w_next = S_RD;
      default: w_next = S_IDLE;
    endcase
  end

  // Status flag updates: a set event in the same edge as a STATUS read wins.
  always_comb begin
    w_done_n   = r_done & ~w_rd_stat;
    w_ab_n     = r_aborted & ~w_rd_stat;
    w_irq_en_n = w_ctrl_wr ? data_i[3] : r_irq_en;
    if (w_start) begin
      w_done_n = (r_len == 16'd0);
      w_ab_n   = 1'b0;
    end
    if (r_state == S_WR) begin
      if (w_last)            w_done_n = 1'b1;
      else if (r_abort_pend) w_ab_n   = 1'b1;
    end
    if (r_state == S_REQ && r_abort_pend) w_ab_n = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_buf        <= '0;
      r_wcnt       <= '0;
      r_last_addr  <= '0;
      r_src_fix    <= 1'b0;
      r_dst_fix    <= 1'b0;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_last_addr <= w_mem_addr;
      r_wcnt      <= (r_state == S_WAIT) ? r_wcnt + 2'd1 : 2'd0;
      r_done      <= w_done_n;
      r_aborted   <= w_ab_n;
      r_irq_en    <= w_irq_en_n;
      r_irq       <= (w_done_n | w_ab_n) & w_irq_en_n;

      if (w_cfg_wr) begin
        case (addr_i)
          3'd0: r_src[7:0]        <= data_i;
          3'd1: r_src[ADDR_W-1:8] <= data_i;
          3'd2: r_dst[7:0]        <= data_i;
          3'd3: r_dst[ADDR_W-1:8] <= data_i;
          3'd4: r_len[7:0]        <= data_i;
          3'd5: r_len[15:8]       <= data_i;
          3'd6: begin
            r_src_fix <= data_i[1];
            r_dst_fix <= data_i[2];
          end
          default: ;
        endcase
      end

      // A pending abort is dropped whenever the engine returns to idle.
      if (w_next == S_IDLE)  r_abort_pend <= 1'b0;
      else if (w_abort_wr)   r_abort_pend <= 1'b1;

      if (r_state == S_LATCH) r_buf <= mem_data_i;

      if (r_state == S_WR) begin
        if (!r_src_fix) r_src <= r_src + 1'b1;
        if (!r_dst_fix) r_dst <= r_dst + 1'b1;
        r_len <= r_len - 16'd1;
      end
    end
  end

  always_comb begin
    case (r_state)
      S_RD, S_WAIT, S_LATCH: w_mem_addr = r_src;
      S_WR:                  w_mem_addr = r_dst;
      default:               w_mem_addr = r_last_addr;
    endcase
  end

  always_comb begin
    case (addr_i)
      3'd0:    data_o = r_src[7:0];
      3'd1:    data_o = r_src[ADDR_W-1:8];
      3'd2:    data_o = r_dst[7:0];
      3'd3:    data_o = r_dst[ADDR_W-1:8];
      3'd4:    data_o = r_len[7:0];
      3'd5:    data_o = r_len[15:8];
      3'd7:    data_o = {4'b0, r_irq_en, r_aborted, r_done, w_busy};
      default: data_o = 8'h00;
    endcase
  end

  assign mem_addr_o = w_mem_addr;
  assign mem_we_o   = (r_state == S_WR);
  assign mem_data_o = r_buf;
  assign bus_req_o  = w_busy;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Directed bench for dma_copy_ctrl: one instance at RD_LAT=1, one at RD_LAT=2, sharing a RAM model.
module tb_dma_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, rw;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  int          sel;
  logic        gnt2;

  logic        cs1, cs2;
  logic [7:0]  rd1, rd2;
  logic        br1, br2, we1, we2, irq1, irq2;
  logic [15:0] ma1, ma2;
  logic [7:0]  wd1, wd2;
  logic [7:0]  rq1, rq2a, rq2;

  logic [7:0]  ram [0:65535];
  logic        pl_en;
  logic [15:0] pl_a;
  logic [7:0]  pl_d;

  int total = 0;
  int bad   = 0;
  int cnt1  = 0;

  always #5 clk = ~clk;

  assign cs1 = cs && (sel == 0);
  assign cs2 = cs && (sel == 1);

  dma_copy_ctrl #(.RD_LAT(1), .ADDR_W(16)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .cs_i(cs1), .R_W_n(rw), .addr_i(addr),
    .data_i(wdata), .data_o(rd1), .bus_req_o(br1), .bus_gnt_i(1'b1),
    .mem_addr_o(ma1), .mem_we_o(we1), .mem_data_o(wd1), .mem_data_i(rq1), .irq_o(irq1));

  dma_copy_ctrl #(.RD_LAT(2), .ADDR_W(16)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .cs_i(cs2), .R_W_n(rw), .addr_i(addr),
    .data_i(wdata), .data_o(rd2), .bus_req_o(br2), .bus_gnt_i(gnt2),
    .mem_addr_o(ma2), .mem_we_o(we2), .mem_data_o(wd2), .mem_data_i(rq2), .irq_o(irq2));

  // Synchronous RAM: one write port shared by both engines and the preload path.
  always @(posedge clk) begin
    if (we1)        ram[ma1]  <= wd1;
    else if (we2)   ram[ma2]  <= wd2;
    else if (pl_en) ram[pl_a] <= pl_d;
    rq1  <= ram[ma1];
    rq2a <= ram[ma2];
    rq2  <= rq2a;
    if (br1) cnt1 <= cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int s, input logic [2:0] a, input logic [7:0] d);
    sel = s; cs = 1'b1; rw = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input int s, input logic [2:0] a, output logic [7:0] v);
    sel = s; cs = 1'b1; rw = 1'b1; addr = a;
    #1 v = (s == 0) ? rd1 : rd2;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic rchk(input int s, input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] v;
    rd(s, a, v);
    chk(tag, {24'h0, v}, {24'h0, exp});
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic prog(input int s, input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    wr(s, 3'd0, src[7:0]); wr(s, 3'd1, src[15:8]);
    wr(s, 3'd2, dst[7:0]); wr(s, 3'd3, dst[15:8]);
    wr(s, 3'd4, len[7:0]); wr(s, 3'd5, len[15:8]);
  endtask

  task automatic wait_idle(input int s, input string tag);
    int n = 0;
    while (((s == 0) ? br1 : br2) && n < 2000) begin
      @(negedge clk); n++;
    end
    total++;
    assert (n < 2000) else begin bad++; $error("FAIL %s timeout observed=%0d expected<2000", tag, n); end
  endtask

  task automatic wait_addr(input int s, input logic [15:0] a, input string tag);
    int n = 0;
    while (((s == 0) ? ma1 : ma2) !== a && n < 2000) begin
      @(negedge clk); n++;
    end
    total++;
    assert (n < 2000) else begin bad++; $error("FAIL %s timeout observed=%0d expected<2000", tag, n); end
  endtask

  task automatic wait_we1(input string tag);
    int n = 0;
    while (we1 !== 1'b1 && n < 2000) begin
      @(negedge clk); n++;
    end
    total++;
    assert (n < 2000) else begin bad++; $error("FAIL %s timeout observed=%0d expected<2000", tag, n); end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; cs = 1'b0; rw = 1'b1; addr = '0; wdata = '0; sel = 0;
    gnt2 = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_breq", {31'h0, br1}, 32'h0);
    chk("rst_we", {31'h0, we1}, 32'h0);
    chk("rst_maddr", {16'h0, ma1}, 32'h0);
    chk("rst_mdata", {24'h0, wd1}, 32'h0);
    chk("rst_irq", {31'h0, irq1}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rchk(0, 3'd7, 8'h00, "rst_status");

    // basic copy, RD_LAT=1
    poke(16'h1000, 8'h11); poke(16'h1001, 8'h22); poke(16'h1002, 8'h33); poke(16'h1003, 8'h44);
    prog(0, 16'h1000, 16'h2000, 16'h0004);
    c0 = cnt1;
    wr(0, 3'd6, 8'h01);
    wait_idle(0, "basic_wait");
    chk("basic_req_cycles", cnt1 - c0, 32'd13);
    chk("basic_d0", {24'h0, ram[16'h2000]}, 32'h11);
    chk("basic_d1", {24'h0, ram[16'h2001]}, 32'h22);
    chk("basic_d2", {24'h0, ram[16'h2002]}, 32'h33);
    chk("basic_d3", {24'h0, ram[16'h2003]}, 32'h44);
    rchk(0, 3'd7, 8'h02, "basic_status");
    rchk(0, 3'd4, 8'h00, "basic_len_l");
    rchk(0, 3'd5, 8'h00, "basic_len_h");
    rchk(0, 3'd0, 8'h04, "basic_src_l");
    rchk(0, 3'd1, 8'h10, "basic_src_h");
    rchk(0, 3'd2, 8'h04, "basic_dst_l");
    rchk(0, 3'd3, 8'h20, "basic_dst_h");

    // zero length with IRQ enabled
    c0 = cnt1;
    wr(0, 3'd6, 8'h09);
    chk("zero_irq_set", {31'h0, irq1}, 32'h1);
    rchk(0, 3'd7, 8'h0A, "zero_status");
    chk("zero_irq_clr", {31'h0, irq1}, 32'h0);
    rchk(0, 3'd7, 8'h08, "zero_status_clr");
    chk("zero_no_req", cnt1 - c0, 32'd0);

    // fill with destination wrap, source fixed
    poke(16'h0300, 8'hA5); poke(16'hFFFE, 8'h00); poke(16'hFFFF, 8'h00); poke(16'h0000, 8'h00);
    prog(0, 16'h0300, 16'hFFFE, 16'h0003);
    wr(0, 3'd6, 8'h03);
    wait_idle(0, "fill_wait");
    chk("fill_fffe", {24'h0, ram[16'hFFFE]}, 32'hA5);
    chk("fill_ffff", {24'h0, ram[16'hFFFF]}, 32'hA5);
    chk("fill_0000", {24'h0, ram[16'h0000]}, 32'hA5);
    rchk(0, 3'd2, 8'h01, "fill_dst_l");
    rchk(0, 3'd3, 8'h00, "fill_dst_h");
    rchk(0, 3'd0, 8'h00, "fill_src_l");
    rchk(0, 3'd1, 8'h03, "fill_src_h");
    rchk(0, 3'd7, 8'h02, "fill_status");

    // grant drop during byte 2's WAIT, RD_LAT=2
    poke(16'h4000, 8'h5A); poke(16'h4001, 8'h6B); poke(16'h4002, 8'h7C); poke(16'h4003, 8'h8D);
    poke(16'h5000, 8'h00); poke(16'h5001, 8'h00); poke(16'h5002, 8'h00); poke(16'h5003, 8'h00);
    prog(1, 16'h4000, 16'h5000, 16'h0004);
    wr(1, 3'd6, 8'h01);
    wait_addr(1, 16'h4001, "gnt_wait_rd2");
    @(negedge clk);
    gnt2 = 1'b0;
    repeat (8) @(negedge clk);
    chk("gnt_byte2_done", {24'h0, ram[16'h5001]}, 32'h6B);
    chk("gnt_byte3_held", {24'h0, ram[16'h5002]}, 32'h00);
    chk("gnt_req_held", {31'h0, br2}, 32'h1);
    chk("gnt_no_we", {31'h0, we2}, 32'h0);
    rchk(1, 3'd4, 8'h02, "gnt_len_mid");
    gnt2 = 1'b1;
    wait_idle(1, "gnt_wait_done");
    chk("gnt_d0", {24'h0, ram[16'h5000]}, 32'h5A);
    chk("gnt_d2", {24'h0, ram[16'h5002]}, 32'h7C);
    chk("gnt_d3", {24'h0, ram[16'h5003]}, 32'h8D);
    rchk(1, 3'd7, 8'h02, "gnt_status");

    // abort after byte 5's read; SRC_L write while busy must be ignored
    poke(16'h1004, 8'h55); poke(16'h1005, 8'h66);
    poke(16'h3005, 8'h00); poke(16'h3006, 8'h00);
    prog(0, 16'h1000, 16'h3000, 16'h0100);
    wr(0, 3'd6, 8'h01);
    wr(0, 3'd0, 8'h77);
    wait_addr(0, 16'h1005, "abort_wait_rd5");
    wr(0, 3'd6, 8'h80);
    wait_idle(0, "abort_wait_idle");
    chk("abort_byte5", {24'h0, ram[16'h3005]}, 32'h66);
    chk("abort_byte6_none", {24'h0, ram[16'h3006]}, 32'h00);
    rchk(0, 3'd7, 8'h04, "abort_status");
    rchk(0, 3'd4, 8'hFA, "abort_len_l");
    rchk(0, 3'd5, 8'h00, "abort_len_h");
    rchk(0, 3'd0, 8'h06, "abort_src_l");
    rchk(0, 3'd2, 8'h06, "abort_dst_l");

    // synchronous reset mid-WR
    prog(0, 16'h1000, 16'h2100, 16'h0004);
    wr(0, 3'd6, 8'h09);
    wait_we1("rst_wait_wr");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_breq", {31'h0, br1}, 32'h0);
    chk("mrst_we", {31'h0, we1}, 32'h0);
    chk("mrst_irq", {31'h0, irq1}, 32'h0);
    chk("mrst_partial", {24'h0, ram[16'h2100]}, 32'h11);
    rchk(0, 3'd7, 8'h00, "mrst_status");
    for (int i = 0; i < 6; i++) rchk(0, 3'(i), 8'h00, "mrst_reg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
